// File: rtl/reg_access_seq_pkg.sv
// Shared types and constants for the register-access sequencer.
package reg_access_seq_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 2;

    localparam logic RF_READ  = 1'b1;
    localparam logic RF_WRITE = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ     = 3'd1,
        S_CAPTURE  = 3'd2,
        S_ISSUE    = 3'd3,
        S_WAIT_RES = 3'd4,
        S_WRITE    = 3'd5
    } state_t;

endpackage

// File: rtl/reg_access_seq_if.sv
// Request, register-bank and ALU signals of the sequencer, bundled with directional modports.
interface reg_access_seq_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) ();

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_rs1;
    logic [ADDR_W-1:0] req_rs2;
    logic [ADDR_W-1:0] req_rd;
    logic              req_wb;

    logic              rf_rw;
    logic [ADDR_W-1:0] rf_add1o;
    logic [ADDR_W-1:0] rf_add2o;
    logic [DATA_W-1:0] rf_op1;
    logic [DATA_W-1:0] rf_op2;
    logic [ADDR_W-1:0] rf_add1i;
    logic [ADDR_W-1:0] rf_add2i;
    logic [DATA_W-1:0] rf_ip1;
    logic [DATA_W-1:0] rf_ip2;

    logic              opnd_valid;
    logic              opnd_ready;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;

    logic              res_valid;
    logic [DATA_W-1:0] res_data;

    logic              busy;

    modport master (
        input  req_valid, req_rs1, req_rs2, req_rd, req_wb,
        input  rf_op1, rf_op2, opnd_ready, res_valid, res_data,
        output req_ready, rf_rw, rf_add1o, rf_add2o, rf_add1i, rf_add2i,
        output rf_ip1, rf_ip2, opnd_valid, opnd_a, opnd_b, busy
    );

    modport slave (
        output req_valid, req_rs1, req_rs2, req_rd, req_wb,
        output rf_op1, rf_op2, opnd_ready, res_valid, res_data,
        input  req_ready, rf_rw, rf_add1o, rf_add2o, rf_add1i, rf_add2i,
        input  rf_ip1, rf_ip2, opnd_valid, opnd_a, opnd_b, busy
    );

endinterface

// File: rtl/reg_access_seq.sv
// Sequences one instruction at a time: read two registers, hand operands to the ALU,
// and optionally write the ALU result back to the destination register.
module reg_access_seq
    import reg_access_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    reg_access_seq_if.master  bus
);

    state_t            state_q;
    state_t            state_nx;

    logic [ADDR_W-1:0] rs1_q;
    logic [ADDR_W-1:0] rs2_q;
    logic [ADDR_W-1:0] rd_q;
    logic              wb_q;
    logic [DATA_W-1:0] opnd_a_q;
    logic [DATA_W-1:0] opnd_b_q;
    logic [DATA_W-1:0] res_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            wb_q     <= 1'b0;
            opnd_a_q <= '0;
            opnd_b_q <= '0;
            res_q    <= '0;
        end else begin
            state_q <= state_nx;
            if (state_q == S_IDLE && bus.req_valid) begin
                rs1_q <= bus.req_rs1;
                rs2_q <= bus.req_rs2;
                rd_q  <= bus.req_rd;
                wb_q  <= bus.req_wb;
            end
            // Bank data has had the whole READ cycle to settle by now.
            if (state_q == S_CAPTURE) begin
                opnd_a_q <= bus.rf_op1;
                opnd_b_q <= bus.rf_op2;
            end
            if (state_q == S_WAIT_RES && bus.res_valid) begin
                res_q <= bus.res_data;
            end
        end
    end

    always_comb begin
        state_nx = state_q;
        unique case (state_q)
            S_IDLE:     if (bus.req_valid) state_nx = S_READ;
            S_READ:     state_nx = S_CAPTURE;
            S_CAPTURE:  state_nx = S_ISSUE;
            S_ISSUE:    if (bus.opnd_ready) state_nx = wb_q ? S_WAIT_RES : S_IDLE;
            S_WAIT_RES: if (bus.res_valid) state_nx = S_WRITE;
            S_WRITE:    state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    // Outputs come only from the state register and latched fields, never from inputs.
    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.opnd_valid = (state_q == S_ISSUE);
    assign bus.rf_rw      = (state_q == S_WRITE) ? RF_WRITE : RF_READ;
    assign bus.rf_add1o   = rs1_q;
    assign bus.rf_add2o   = rs2_q;
    assign bus.rf_add1i   = rd_q;
    assign bus.rf_add2i   = rd_q;
    assign bus.rf_ip1     = res_q;
    assign bus.rf_ip2     = res_q;
    assign bus.opnd_a     = opnd_a_q;
    assign bus.opnd_b     = opnd_b_q;

endmodule

// File: tb/tb_reg_access_seq.sv
// Bench for reg_access_seq with a behavioural four-entry register bank and a scoreboard monitor.
module tb_reg_access_seq;

    logic clk;
    logic rst;

    reg_access_seq_if #(.DATA_W(8), .ADDR_W(2)) bus ();

    reg_access_seq #(.DATA_W(8), .ADDR_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank: asynchronous read, write on the clock edge when rf_rw is low.
    logic [7:0] bank [4];
    logic       pl_we;
    logic [1:0] pl_addr;
    logic [7:0] pl_data;

    always @(posedge clk) begin
        if (pl_we) begin
            bank[pl_addr] <= pl_data;
        end else if (bus.rf_rw == 1'b0) begin
            bank[bus.rf_add1i] <= bus.rf_ip1;
            bank[bus.rf_add2i] <= bus.rf_ip2;
        end
    end

    assign bus.rf_op1 = bank[bus.rf_add1o];
    assign bus.rf_op2 = bank[bus.rf_add2o];

    typedef struct {
        bit         is_wr;
        logic [7:0] a;
        logic [7:0] b;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   wr_count = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.opnd_valid && bus.opnd_ready) begin
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_issue", 32'(bus.opnd_a), 32'hFFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_issue_kind", 32'(1'b0), 32'(e.is_wr));
                    chk("sb_opnd_a", 32'(bus.opnd_a), 32'(e.a));
                    chk("sb_opnd_b", 32'(bus.opnd_b), 32'(e.b));
                end
            end
            if (bus.rf_rw == 1'b0) begin
                wr_count++;
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_write", 32'(bus.rf_ip1), 32'hFFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_write_kind", 32'(1'b1), 32'(e.is_wr));
                    chk("sb_wr_addr1", 32'(bus.rf_add1i), 32'(e.a));
                    chk("sb_wr_addr2", 32'(bus.rf_add2i), 32'(e.a));
                    chk("sb_wr_data1", 32'(bus.rf_ip1), 32'(e.b));
                    chk("sb_wr_data2", 32'(bus.rf_ip2), 32'(e.b));
                end
            end
        end
    end

    task automatic preload(input logic [1:0] addr, input logic [7:0] data);
        @(posedge clk); #1;
        pl_we   = 1'b1;
        pl_addr = addr;
        pl_data = data;
        @(posedge clk); #1;
        pl_we   = 1'b0;
    endtask

    task automatic check_reset_values(input string nm);
        chk({nm, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
        chk({nm, "_opnd_valid"}, 32'(bus.opnd_valid), 32'd0);
        chk({nm, "_rf_rw"}, 32'(bus.rf_rw), 32'd1);
        chk({nm, "_addrs"}, {24'd0, bus.rf_add1o, bus.rf_add2o, bus.rf_add1i, bus.rf_add2i}, 32'd0);
        chk({nm, "_opnds"}, {16'd0, bus.opnd_a, bus.opnd_b}, 32'd0);
        chk({nm, "_wdata"}, {16'd0, bus.rf_ip1, bus.rf_ip2}, 32'd0);
    endtask

    // Issue one request and walk it through the sequencer, counting edges from acceptance to IDLE.
    task automatic do_req(input string nm, input logic [1:0] rs1, input logic [1:0] rs2,
                          input logic [1:0] rd, input logic wb, input logic [7:0] ea,
                          input logic [7:0] eb, input logic [7:0] res, input int hold,
                          input bit spur, input bit rst_wait, input int exp_cyc);
        exp_t e;
        int   cyc;
        int   guard;
        e.is_wr = 1'b0; e.a = ea; e.b = eb;
        sbq.push_back(e);
        if (wb && !rst_wait) begin
            e.is_wr = 1'b1; e.a = {6'd0, rd}; e.b = res;
            sbq.push_back(e);
        end
        chk({nm, "_ready_before"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_rs1    = rs1;
        bus.req_rs2    = rs2;
        bus.req_rd     = rd;
        bus.req_wb     = wb;
        bus.opnd_ready = (hold == 0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        cyc = 1;
        guard = 0;
        while (!bus.opnd_valid && guard < 20) begin
            @(posedge clk); #1;
            cyc++;
            guard++;
        end
        if (!bus.opnd_valid) begin
            chk({nm, "_issue_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({nm, "_lat_issue"}, 32'(cyc), 32'd3);
        if (spur) begin
            bus.res_valid = 1'b1;
            bus.res_data  = 8'h55;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            cyc++;
            bus.res_valid = 1'b0;
            chk({nm, "_hold_valid"}, 32'(bus.opnd_valid), 32'd1);
            chk({nm, "_hold_opnds"}, {16'd0, bus.opnd_a, bus.opnd_b}, {16'd0, ea, eb});
        end
        bus.opnd_ready = 1'b1;
        @(posedge clk); #1;
        cyc++;
        bus.opnd_ready = 1'b0;
        bus.res_valid  = 1'b0;
        if (wb) begin
            if (rst_wait) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check_reset_values({nm, "_rst"});
                return;
            end
            bus.res_valid = 1'b1;
            bus.res_data  = res;
            @(posedge clk); #1;
            cyc++;
            bus.res_valid = 1'b0;
            bus.res_data  = 8'h00;
            @(posedge clk); #1;
            cyc++;
        end
        chk({nm, "_idle_after"}, 32'(bus.req_ready), 32'd1);
        chk({nm, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wr_before;
        rst            = 1'b1;
        pl_we          = 1'b0;
        pl_addr        = 2'd0;
        pl_data        = 8'h00;
        bus.req_valid  = 1'b0;
        bus.req_rs1    = 2'd0;
        bus.req_rs2    = 2'd0;
        bus.req_rd     = 2'd0;
        bus.req_wb     = 1'b0;
        bus.opnd_ready = 1'b0;
        bus.res_valid  = 1'b0;
        bus.res_data   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_values("reset");

        // Write-back: R1+R2 into R3.
        preload(2'd1, 8'h12);
        preload(2'd2, 8'h34);
        do_req("wb_basic", 2'd1, 2'd2, 2'd3, 1'b1, 8'h12, 8'h34, 8'h46, 0, 1'b0, 1'b0, 6);
        chk("wb_basic_r3", 32'(bank[3]), 32'h46);

        // Read-only from R0 on both ports: no write may happen.
        preload(2'd0, 8'hFF);
        wr_before = wr_count;
        do_req("rd_only", 2'd0, 2'd0, 2'd1, 1'b0, 8'hFF, 8'hFF, 8'h00, 0, 1'b0, 1'b0, 4);
        chk("rd_only_no_write", 32'(wr_count - wr_before), 32'd0);
        chk("rd_only_r1_kept", 32'(bank[1]), 32'h12);

        // Backpressure: ALU not ready for 5 cycles.
        do_req("stall", 2'd1, 2'd2, 2'd0, 1'b0, 8'h12, 8'h34, 8'h00, 5, 1'b0, 1'b0, 9);

        // Reset while waiting for the result: R3 must keep 0x46.
        do_req("rst_wait", 2'd1, 2'd2, 2'd3, 1'b1, 8'h12, 8'h34, 8'hAA, 0, 1'b0, 1'b1, 0);
        @(posedge clk); #1;
        chk("rst_wait_r3_kept", 32'(bank[3]), 32'h46);

        // Source equals destination: operand is the old value.
        preload(2'd2, 8'h05);
        do_req("src_eq_dst", 2'd2, 2'd1, 2'd2, 1'b1, 8'h05, 8'h12, 8'h0A, 0, 1'b0, 1'b0, 6);
        chk("src_eq_dst_r2", 32'(bank[2]), 32'h0A);

        // Stray res_valid during ISSUE is ignored; only the WAIT_RES result is written.
        do_req("spurious", 2'd1, 2'd1, 2'd0, 1'b1, 8'h12, 8'h12, 8'h77, 2, 1'b1, 1'b0, 8);
        chk("spurious_r0", 32'(bank[0]), 32'h77);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_access_seq.md
REG_ACCESS_SEQ -- requirements
Module: reg_access_seq

Interface
REQ-001 Parameter DATA_W, default 8: width of register data, operands and result.
REQ-002 Parameter ADDR_W, default 2: width of register addresses (4 registers).
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  1  instruction request present; req_ready  out  1  sequencer can accept a request.
REQ-006 req_rs1, req_rs2, req_rd  in  ADDR_W each  source 1, source 2 and destination register addresses.
REQ-007 req_wb  in  1  1 means the result is written back to req_rd; 0 means read-only.
REQ-008 rf_rw  out  1  register bank mode: 1 = read, 0 = write.
REQ-009 rf_add1o, rf_add2o  out  ADDR_W each  bank read addresses; rf_op1, rf_op2  in  DATA_W each  bank read data.
REQ-010 rf_add1i, rf_add2i  out  ADDR_W each  bank write addresses; rf_ip1, rf_ip2  out  DATA_W each  bank write data.
REQ-011 opnd_valid  out  1; opnd_ready  in  1; opnd_a, opnd_b  out  DATA_W each  operands to the ALU.
REQ-012 res_valid  in  1; res_data  in  DATA_W  result from the ALU.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, READ, CAPTURE, ISSUE, WAIT_RES, WRITE.
REQ-015 IDLE: req_ready=1; on req_valid=1, latch rs1, rs2, rd and wb, then go to READ; otherwise stay.
REQ-016 READ: rf_rw=1, rf_add1o=rs1, rf_add2o=rs2; go to CAPTURE after one cycle, so the bank gets a full cycle to settle.
REQ-017 CAPTURE: keep READ addresses; latch rf_op1 into opnd_a and rf_op2 into opnd_b; go to ISSUE.
REQ-018 ISSUE: opnd_valid=1; opnd_a and opnd_b stay stable until the handshake.
REQ-019 ISSUE exit: on opnd_ready=1, go to WAIT_RES if wb=1, else to IDLE.
REQ-020 WAIT_RES: wait for res_valid=1, latch res_data, then go to WRITE; res_valid outside WAIT_RES is ignored.
REQ-021 WRITE: rf_rw=0, rf_add1i=rf_add2i=rd, rf_ip1=rf_ip2=latched result, held for exactly one cycle, then go to IDLE.
REQ-022 Both write ports carry identical address and data, so the bank's dual write never conflicts.
REQ-023 rf_rw SHALL be 0 only in WRITE; in all other states it is 1, so no spurious writes.
REQ-024 All outputs are registered or decoded from the state register only; no combinational path from any input to any output.
REQ-025 Throughput: minimum 4 cycles per read-only request and 6 cycles per write-back request, with zero-wait handshakes.
REQ-026 Source equals destination (e.g. rs1=rd) is legal: the operand is the pre-write value, and the write occurs later.
REQ-027 A new request is accepted only in IDLE, so requests never overlap and no hazard logic is needed.
REQ-028 Address and data arithmetic is unsigned at ADDR_W/DATA_W width, with no extension or truncation.

Reset
REQ-029 When rst=1 at a clock edge, state goes to IDLE regardless of the current state, and any in-flight request is discarded without writing.
REQ-030 Reset values: req_ready=1, busy=0, opnd_valid=0, rf_rw=1.
REQ-031 Reset values: all address, operand, write-data and latched-field registers are 0.

Structure
REQ-032 A shared package holds the state enum type, DATA_W/ADDR_W defaults and the RF_READ=1/RF_WRITE=0 constants.
REQ-033 The design is one module with no sub-module; the bench instantiates reg_access_seq together with the existing register bank.

Verification
REQ-034 Preload R1=0x12, R2=0x34; request rs1=1, rs2=2, rd=3, wb=1; ALU returns 0x46 -> opnd_a=0x12, opnd_b=0x34, R3=0x46, 6 cycles from request to IDLE.
REQ-035 Read-only request (wb=0) rs1=0, rs2=0 with R0=0xFF -> opnd_a=opnd_b=0xFF, rf_rw never 0, back to IDLE after 4 cycles.
REQ-036 Hold opnd_ready=0 for 5 cycles in ISSUE -> opnd_valid stays 1 and operands stay stable; state advances one cycle after opnd_ready=1.
REQ-037 Assert rst during WAIT_RES -> next cycle is IDLE with reset values, and the destination register is unchanged.
REQ-038 rs1=rd=2, R2=0x05, ALU returns 0x0A -> opnd_a=0x05, then R2=0x0A after WRITE.
REQ-039 Pulse res_valid while in ISSUE, then later in WAIT_RES with 0x77 -> only 0x77 is written.
